// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM state encoding
// Used by both the receiver and the transmitter of the UART library.
package uart_pkg;

  localparam int OVERSAMPLE        = 16;
  localparam int DATA_BITS         = 8;
  localparam int START_SAMPLE_TICK = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver-to-consumer byte interface
// Signals:
//   data      [7:0] last received byte
//   valid           one-cycle strobe, data good while high
//   frame_err       one-cycle strobe, stop bit was low
//   busy            frame in progress
// Modports: master (receiver drives), slave (consumer observes).
interface uart_rx_if;

  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output data, output valid, output frame_err, output busy);
  modport slave  (input  data, input  valid, input  frame_err, input  busy);

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   clr   in  restart the count so the next tick is BAUD_DIV clk away
//   tick  out high for one clk on the terminal count
module uart_baud_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampled, mid-bit sampling
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   rxd  in   serial line, asynchronous, idle high
//   rx   uart_rx_if.master: data / valid / frame_err / busy
module uart_rx #(
  parameter int BAUD_DIV   = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rxd,
  uart_rx_if.master rx
);

  import uart_pkg::*;

  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] START_TICK = 4'(START_SAMPLE_TICK - 1);
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

  uart_state_e state_q, state_d;

  logic       sync1_q, sync2_q, sync3_q;
  logic       line, fall, tick;
  logic       start_clr, tick_clr, shift_en, load_data, set_ferr;
  logic [3:0] tick_cnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q, data_q;
  logic       valid_q, ferr_q;

  // Two flops tame metastability; the third only remembers the previous
  // synchronized level so a falling edge can be seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign line = sync2_q;
  assign fall = sync3_q & ~sync2_q;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_clr),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    start_clr = 1'b0;
    tick_clr  = 1'b0;
    shift_en  = 1'b0;
    load_data = 1'b0;
    set_ferr  = 1'b0;
    case (state_q)
      IDLE: begin
        // Only an edge starts a frame, so a line held low never re-triggers.
        if (fall) begin
          state_d   = START;
          start_clr = 1'b1;
        end
      end
      START: begin
        if (tick && tick_cnt_q == START_TICK) begin
          // Re-phase the tick counter to mid-bit; a high line was a glitch.
          tick_clr = 1'b1;
          state_d  = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && tick_cnt_q == LAST_TICK) begin
          shift_en = 1'b1;
          if (bit_idx_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && tick_cnt_q == LAST_TICK) begin
          state_d = IDLE;
          if (line) load_data = 1'b1;
          else      set_ferr  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= load_data;
      ferr_q  <= set_ferr;
      if (load_data) data_q <= shift_q;
      if (start_clr || tick_clr) tick_cnt_q <= '0;
      else if (tick)             tick_cnt_q <= tick_cnt_q + 4'd1;
      if (tick_clr)      bit_idx_q <= '0;
      else if (shift_en) bit_idx_q <= bit_idx_q + 3'd1;
      // LSB arrives first, so shift right and enter at the top.
      if (shift_en) shift_q <= {line, shift_q[7:1]};
    end
  end

  assign rx.data      = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  localparam int B          = 4;
  localparam int BIT        = 16 * B;
  localparam int LAT        = 3 + 152 * B;
  localparam int GLITCH_END = 3 + 8 * B;

  logic clk = 1'b0;
  logic rst;
  logic rxd;

  uart_rx_if rx_if ();

  uart_rx #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .rx  (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; bit err; logic [7:0] d;} ev_t;
  typedef struct {int s; int e;} iv_t;

  ev_t        exp_q[$];
  iv_t        busy_q[$];
  logic [7:0] model_data = 8'h00;

  int n_vec = 0;
  int n_bad = 0;
  int nv = 0;
  int nf = 0;
  int last_valid_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    bit ev, ef, eb;
    if (rst === 1'b0) begin
      ev = 1'b0;
      ef = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        if (exp_q[0].err) ef = 1'b1;
        else begin
          ev = 1'b1;
          model_data = exp_q[0].d;
        end
        void'(exp_q.pop_front());
      end
      while (busy_q.size() > 0 && busy_q[0].e <= cyc) void'(busy_q.pop_front());
      eb = (busy_q.size() > 0 && busy_q[0].s <= cyc);
      chk("valid", rx_if.valid, ev);
      chk("frame_err", rx_if.frame_err, ef);
      chk("busy", rx_if.busy, eb);
      chk("data", rx_if.data, model_data);
      if (rx_if.valid) begin
        nv++;
        last_valid_cyc = cyc;
      end
      if (rx_if.frame_err) nf++;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ideal 8N1 transmitter; len is the bit period in clk.
  task automatic send_frame(input logic [7:0] b, input int len, input bit stop_ok, output int k);
    k   = cyc;
    rxd = 1'b0;
    exp_q.push_back('{k + LAT, !stop_ok, b});
    busy_q.push_back('{k + 3, k + LAT});
    hold(len);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      hold(len);
    end
    rxd = stop_ok;
    hold(len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, %0d vectors so far", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    int k, v0, f0, len, gap;
    logic [7:0] b;
    bit ok;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", rx_if.data, 8'h00);
    chk("reset_valid", rx_if.valid, 1'b0);
    chk("reset_ferr", rx_if.frame_err, 1'b0);
    chk("reset_busy", rx_if.busy, 1'b0);
    rst = 1'b0;
    hold(20);

    send_frame(8'hA5, BIT, 1'b1, k);
    hold(10);
    chk("a5_data", rx_if.data, 8'hA5);
    chk("a5_latency", last_valid_cyc - k, 611);

    v0 = nv;
    send_frame(8'h00, BIT, 1'b1, k);
    send_frame(8'hFF, BIT, 1'b1, k);
    hold(10);
    chk("b2b_count", nv - v0, 2);
    chk("b2b_data", rx_if.data, 8'hFF);

    v0 = nv;
    f0 = nf;
    k  = cyc;
    rxd = 1'b0;
    busy_q.push_back('{k + 3, k + GLITCH_END});
    hold(20);
    chk("glitch_busy_mid", rx_if.busy, 1'b1);
    rxd = 1'b1;
    hold(100);
    chk("glitch_valid", nv - v0, 0);
    chk("glitch_ferr", nf - f0, 0);
    chk("glitch_busy_end", rx_if.busy, 1'b0);

    v0 = nv;
    f0 = nf;
    send_frame(8'h3C, BIT, 1'b0, k);
    hold(10 * BIT);
    rxd = 1'b1;
    hold(100);
    chk("break_ferr", nf - f0, 1);
    chk("break_valid", nv - v0, 0);
    chk("break_data", rx_if.data, 8'hFF);
    send_frame(8'h55, BIT, 1'b1, k);
    hold(10);
    chk("after_break_data", rx_if.data, 8'h55);

    send_frame(8'h96, 62, 1'b1, k);
    hold(10);
    chk("fast_data", rx_if.data, 8'h96);
    send_frame(8'h00, BIT, 1'b1, k);
    send_frame(8'h96, 66, 1'b1, k);
    hold(10);
    chk("slow_data", rx_if.data, 8'h96);

    b  = 8'($urandom);
    k  = cyc;
    rxd = 1'b0;
    busy_q.push_back('{k + 3, k + LAT});
    hold(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      hold(BIT);
    end
    rxd = b[4];
    hold(BIT / 2);
    #2;
    rst = 1'b1;
    exp_q.delete();
    busy_q.delete();
    model_data = 8'h00;
    #1;
    chk("midrst_data", rx_if.data, 8'h00);
    chk("midrst_valid", rx_if.valid, 1'b0);
    chk("midrst_ferr", rx_if.frame_err, 1'b0);
    chk("midrst_busy", rx_if.busy, 1'b0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    v0 = nv;
    hold(200);
    send_frame(8'h81, BIT, 1'b1, k);
    hold(10);
    chk("post_rst_data", rx_if.data, 8'h81);
    chk("post_rst_count", nv - v0, 1);

    repeat (40) begin
      b = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       len = 62;
        1:       len = 64;
        default: len = 66;
      endcase
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, len, ok, k);
      gap = $urandom_range(ok ? 0 : 2, 20);
      if (gap > 0) begin
        rxd = 1'b1;
        hold(gap);
      end
    end
    rxd = 1'b1;
    hold(700);
    chk("events_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
